dca_matrix_tile_iterator: RTL and testbench
===========================================

Name: dca_matrix_tile_iterator

Overview:
- Parametrised successor to the DCA matrix row/column iterator.
- Walks an (num_row × num_col) matrix in rectangular tiles, in row-first or column-first order.
- Emits one element coordinate plus linear address per valid/ready handshake, with tile/element boundary flags.
- Sits between the DCA controller (start/done) and the memory-request generator (stream consumer).

Parameters:
- BW_NUM_ROW, 8, width of row index and num_row_m1
- BW_NUM_COL, 8, width of column index and num_col_m1
- BW_TILE, 4, width of tile_row_m1 / tile_col_m1
- BW_ADDR, 32, width of base_addr, row_stride, out_addr

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous abort; returns to IDLE
- start  in  1  begin traversal; config sampled this cycle
- is_col_first  in  1  1: inner loop walks columns, 0: inner loop walks rows (applies inside and across tiles)
- num_row_m1  in  BW_NUM_ROW  matrix rows minus 1
- num_col_m1  in  BW_NUM_COL  matrix cols minus 1
- tile_row_m1  in  BW_TILE  tile height minus 1
- tile_col_m1  in  BW_TILE  tile width minus 1
- base_addr  in  BW_ADDR  address of element (0,0)
- row_stride  in  BW_ADDR  address delta between rows
- busy  out  1  traversal in progress
- done  out  1  one-cycle pulse after final element accepted
- out_valid  out  1  element available
- out_ready  in  1  consumer accepts
- out_row  out  BW_NUM_ROW  element row
- out_col  out  BW_NUM_COL  element column
- out_addr  out  BW_ADDR  base_addr + out_row*row_stride + out_col, mod 2^BW_ADDR
- out_first_in_tile  out  1  first element of current tile
- out_last_in_tile  out  1  last element of current tile
- out_last  out  1  last element of matrix

Behaviour:
- Reset (rst=1, async): state IDLE; busy=0, done=0, out_valid=0, out_row=0, out_col=0, out_addr=0, all flags 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch all config inputs, load first element (0,0), addr=base_addr → RUN next cycle. out_valid=1 and busy=1 from the first RUN cycle. Latency start→first out_valid: 1 cycle.
- RUN: out_valid=1 continuously. Handshake = out_valid & out_ready.
  - No handshake: all out_* held stable.
  - Handshake on a non-last element: advance to the next element in the following cycle.
  - Handshake on the out_last element: go to DONE, out_valid=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start is accepted again in the cycle after DONE.
- Traversal order, col-first:
  - Inside a tile: column increments; at tile column end, column resets to tile column base and row increments.
  - After the tile's last element: next tile along columns; after the last column tile, return to column tile 0 and move to the next row tile.
- Traversal order, row-first: same with the roles of row and column swapped.
- Clipping: tile row end = min(tile_row_base + tile_row_m1, num_row_m1); same for columns. Edge tiles are smaller; no out-of-range element is ever emitted.
- Tile origins step by tile_*_m1+1.
- out_first_in_tile = element equals the tile origin. out_last_in_tile = element equals the clipped tile end corner.
- out_last = (num_row_m1, num_col_m1); it is always also out_last_in_tile.
- Addresses are computed incrementally (adders only, no multiplier). Wrap is modulo 2^BW_ADDR.
- Config inputs are ignored while busy; only latched values are used.
- start while busy or in DONE is ignored.
- clear (priority over start and handshake) → IDLE next cycle, out_valid=0, busy=0, no done pulse.
- Degenerate 1×1 matrix: one element with first_in_tile, last_in_tile and out_last all 1.
- Tile larger than matrix: a single clipped tile.

Optional Feature:
- Macro DCA_MATRIX_TILE_ITERATOR_INDEX_EN.
- Defined: adds output out_index [BW_NUM_ROW+BW_NUM_COL-1:0], the sequence number of the current element (0 at the first element). It increments on each handshake, clears on start, clear and rst, and holds when there is no handshake.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- num_row_m1=2, num_col_m1=4, tile 2×2 (m1=1,1), col-first, base=0x100, stride=8, out_ready=1 → 15 elements in order (0,0)(0,1)(1,0)(1,1)(0,2)(0,3)(1,2)(1,3)(0,4)(1,4)(2,0)(2,1)(2,2)(2,3)(2,4). (1,4) has addr 0x10C and out_last_in_tile=1. (2,4) has out_last=1. done pulses 1 cycle after (2,4) is accepted.
- Same config, row-first → (0,0)(1,0)(0,1)(1,1)(2,0)(2,1)(0,2)(1,2)(0,3)(1,3)(2,2)(2,3)(0,4)(1,4)(2,4).
- Random out_ready backpressure with 30% stall → sequence identical to the first test; outputs stable during every stall cycle.
- 1×1 matrix, tile 4×4 → single element (0,0), addr=base, first_in_tile=last_in_tile=out_last=1, done 2 cycles after start.
- clear asserted mid-run after the 5th handshake → out_valid=0 and busy=0 next cycle, no done. A new start restarts at (0,0).
- base=0xFFFFFFF8, stride=8, 2×2 matrix, tile 2×2 → addresses 0xFFFFFFF8, 0xFFFFFFF9, 0x00000000, 0x00000001 (modular wrap, col-first).

Source files
------------

// File: rtl/dca_matrix_tile_iterator.sv
// Tiled row/column-first matrix walker emitting (row, col, addr) per handshake.
// Optional feature: define DCA_MATRIX_TILE_ITERATOR_INDEX_EN to add out_index.
module dca_matrix_tile_iterator #(
    parameter int BW_NUM_ROW = 8,
    parameter int BW_NUM_COL = 8,
    parameter int BW_TILE    = 4,
    parameter int BW_ADDR    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  is_col_first,
    input  logic [BW_NUM_ROW-1:0] num_row_m1,
    input  logic [BW_NUM_COL-1:0] num_col_m1,
    input  logic [BW_TILE-1:0]    tile_row_m1,
    input  logic [BW_TILE-1:0]    tile_col_m1,
    input  logic [BW_ADDR-1:0]    base_addr,
    input  logic [BW_ADDR-1:0]    row_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW_NUM_ROW-1:0] out_row,
    output logic [BW_NUM_COL-1:0] out_col,
    output logic [BW_ADDR-1:0]    out_addr,
    output logic                  out_first_in_tile,
    output logic                  out_last_in_tile,
    output logic                  out_last
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
    ,
    output logic [BW_NUM_ROW+BW_NUM_COL-1:0] out_index
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  cf_q, cf_d;
    logic [BW_NUM_ROW-1:0] nrow_q, nrow_d, row_q, row_d, trb_q, trb_d;
    logic [BW_NUM_COL-1:0] ncol_q, ncol_d, col_q, col_d, tcb_q, tcb_d;
    logic [BW_TILE-1:0]    trow_q, trow_d, tcol_q, tcol_d;
    logic [BW_ADDR-1:0]    base_q, base_d, stride_q, stride_d;
    // rowaddr = address of (row, 0); tileaddr = address of (tile row base, 0)
    logic [BW_ADDR-1:0]    rowaddr_q, rowaddr_d, tileaddr_q, tileaddr_d;

    logic [BW_NUM_ROW:0]   row_sum;
    logic [BW_NUM_COL:0]   col_sum;
    logic [BW_NUM_ROW-1:0] row_end;
    logic [BW_NUM_COL-1:0] col_end;
    logic                  run, hs, row_at_end, col_at_end, at_last;

    assign row_sum    = {1'b0, trb_q} + (BW_NUM_ROW+1)'(trow_q);
    assign col_sum    = {1'b0, tcb_q} + (BW_NUM_COL+1)'(tcol_q);
    assign row_end    = (row_sum > {1'b0, nrow_q}) ? nrow_q : row_sum[BW_NUM_ROW-1:0];
    assign col_end    = (col_sum > {1'b0, ncol_q}) ? ncol_q : col_sum[BW_NUM_COL-1:0];
    assign row_at_end = (row_q == row_end);
    assign col_at_end = (col_q == col_end);
    assign at_last    = (row_q == nrow_q) && (col_q == ncol_q);
    assign run        = (state_q == S_RUN);
    assign hs         = run && out_ready;

`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
    logic [BW_NUM_ROW+BW_NUM_COL-1:0] idx_q, idx_d;
    assign out_index = idx_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cf_q       <= 1'b0;
            nrow_q     <= '0;
            ncol_q     <= '0;
            trow_q     <= '0;
            tcol_q     <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            trb_q      <= '0;
            tcb_q      <= '0;
            rowaddr_q  <= '0;
            tileaddr_q <= '0;
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
            idx_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cf_q       <= cf_d;
            nrow_q     <= nrow_d;
            ncol_q     <= ncol_d;
            trow_q     <= trow_d;
            tcol_q     <= tcol_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            row_q      <= row_d;
            col_q      <= col_d;
            trb_q      <= trb_d;
            tcb_q      <= tcb_d;
            rowaddr_q  <= rowaddr_d;
            tileaddr_q <= tileaddr_d;
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
            idx_q      <= idx_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cf_d       = cf_q;
        nrow_d     = nrow_q;
        ncol_d     = ncol_q;
        trow_d     = trow_q;
        tcol_d     = tcol_q;
        base_d     = base_q;
        stride_d   = stride_q;
        row_d      = row_q;
        col_d      = col_q;
        trb_d      = trb_q;
        tcb_d      = tcb_q;
        rowaddr_d  = rowaddr_q;
        tileaddr_d = tileaddr_q;
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
        idx_d      = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    cf_d       = is_col_first;
                    nrow_d     = num_row_m1;
                    ncol_d     = num_col_m1;
                    trow_d     = tile_row_m1;
                    tcol_d     = tile_col_m1;
                    base_d     = base_addr;
                    stride_d   = row_stride;
                    row_d      = '0;
                    col_d      = '0;
                    trb_d      = '0;
                    tcb_d      = '0;
                    rowaddr_d  = base_addr;
                    tileaddr_d = base_addr;
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
                    idx_d      = '0;
`endif
                end
            end
            S_RUN: begin
                if (hs) begin
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
                    idx_d = idx_q + (BW_NUM_ROW+BW_NUM_COL)'(1);
`endif
                    if (at_last) begin
                        state_d = S_DONE;
                    end else if (cf_q) begin
                        if (!col_at_end) begin
                            col_d = col_q + BW_NUM_COL'(1);
                        end else if (!row_at_end) begin
                            col_d     = tcb_q;
                            row_d     = row_q + BW_NUM_ROW'(1);
                            rowaddr_d = rowaddr_q + stride_q;
                        end else if (col_end != ncol_q) begin
                            // next tile to the right, back to the tile's top row
                            tcb_d     = col_end + BW_NUM_COL'(1);
                            col_d     = col_end + BW_NUM_COL'(1);
                            row_d     = trb_q;
                            rowaddr_d = tileaddr_q;
                        end else begin
                            trb_d      = row_end + BW_NUM_ROW'(1);
                            row_d      = row_end + BW_NUM_ROW'(1);
                            rowaddr_d  = rowaddr_q + stride_q;
                            tileaddr_d = rowaddr_q + stride_q;
                            tcb_d      = '0;
                            col_d      = '0;
                        end
                    end else begin
                        if (!row_at_end) begin
                            row_d     = row_q + BW_NUM_ROW'(1);
                            rowaddr_d = rowaddr_q + stride_q;
                        end else if (!col_at_end) begin
                            row_d     = trb_q;
                            rowaddr_d = tileaddr_q;
                            col_d     = col_q + BW_NUM_COL'(1);
                        end else if (row_end != nrow_q) begin
                            // next tile below; row is at tile row end so one stride reaches it
                            trb_d      = row_end + BW_NUM_ROW'(1);
                            row_d      = row_end + BW_NUM_ROW'(1);
                            rowaddr_d  = rowaddr_q + stride_q;
                            tileaddr_d = rowaddr_q + stride_q;
                            col_d      = tcb_q;
                        end else begin
                            trb_d      = '0;
                            row_d      = '0;
                            rowaddr_d  = base_q;
                            tileaddr_d = base_q;
                            tcb_d      = col_end + BW_NUM_COL'(1);
                            col_d      = col_end + BW_NUM_COL'(1);
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
            idx_d   = '0;
`endif
        end
    end

    assign busy              = run;
    assign out_valid         = run;
    assign done              = (state_q == S_DONE);
    assign out_row           = row_q;
    assign out_col           = col_q;
    assign out_addr          = rowaddr_q + BW_ADDR'(col_q);
    assign out_first_in_tile = run && (row_q == trb_q) && (col_q == tcb_q);
    assign out_last_in_tile  = run && row_at_end && col_at_end;
    assign out_last          = run && at_last;

endmodule

// File: tb/tb_dca_matrix_tile_iterator.sv
// Directed bench for dca_matrix_tile_iterator: traversal order, flags, backpressure, clear, wrap.
module tb_dca_matrix_tile_iterator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        is_col_first = 1'b0;
    logic [7:0]  num_row_m1 = '0;
    logic [7:0]  num_col_m1 = '0;
    logic [3:0]  tile_row_m1 = '0;
    logic [3:0]  tile_col_m1 = '0;
    logic [31:0] base_addr = '0;
    logic [31:0] row_stride = '0;
    logic        out_ready = 1'b0;
    logic        busy, done, out_valid, out_first_in_tile, out_last_in_tile, out_last;
    logic [7:0]  out_row, out_col;
    logic [31:0] out_addr;
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
    logic [15:0] out_index;
`endif

    dca_matrix_tile_iterator dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .is_col_first(is_col_first),
        .num_row_m1(num_row_m1), .num_col_m1(num_col_m1),
        .tile_row_m1(tile_row_m1), .tile_col_m1(tile_col_m1),
        .base_addr(base_addr), .row_stride(row_stride),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_addr(out_addr),
        .out_first_in_tile(out_first_in_tile), .out_last_in_tile(out_last_in_tile),
        .out_last(out_last)
`ifdef DCA_MATRIX_TILE_ITERATOR_INDEX_EN
        , .out_index(out_index)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int cf_r[15] = '{0,0,1,1,0,0,1,1,0,1,2,2,2,2,2};
    int cf_c[15] = '{0,1,0,1,2,3,2,3,4,4,0,1,2,3,4};
    int rf_r[15] = '{0,1,0,1,2,2,0,1,0,1,2,2,0,1,2};
    int rf_c[15] = '{0,0,1,1,0,1,2,2,3,3,2,3,4,4,4};
    bit [14:0] cf_first = 15'b101010100010001;
    bit [14:0] cf_lastt = 15'b110101010001000;
    bit [14:0] rf_first = 15'b101010001010001;
    bit [14:0] rf_lastt = 15'b110101000101000;

    logic [7:0]  got_r[32];
    logic [7:0]  got_c[32];
    logic [31:0] got_a[32];
    logic        got_f[32], got_l[32], got_e[32];
    int n_got, done_lat, done_cnt, stall_bad, valid_in_done;

    task automatic start_run(input bit cf, input int nr, input int nc, input int tr,
                             input int tc, input logic [31:0] b, input logic [31:0] s);
        @(negedge clk);
        is_col_first = cf;
        num_row_m1   = 8'(nr);
        num_col_m1   = 8'(nc);
        tile_row_m1  = 4'(tr);
        tile_col_m1  = 4'(tc);
        base_addr    = b;
        row_stride   = s;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Records accepted elements and done timing; leaves the comparisons to each test.
    task automatic capture(input int exp_n, input int stall_pct);
        int since;
        bit have_prev;
        logic [50:0] pv;
        n_got = 0; done_lat = -1; done_cnt = 0; stall_bad = 0; valid_in_done = 0;
        since = 0; have_prev = 0; pv = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (n_got >= exp_n && since >= 4) break;
            out_ready = (int'($urandom_range(99)) >= stall_pct);
            since++;
            if (done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = since;
                if (out_valid) valid_in_done = 1;
            end
            if (have_prev && out_valid &&
                (pv !== {out_row, out_col, out_addr, out_first_in_tile, out_last_in_tile, out_last}))
                stall_bad++;
            have_prev = 0;
            if (out_valid && out_ready) begin
                if (n_got < 32) begin
                    got_r[n_got] = out_row;
                    got_c[n_got] = out_col;
                    got_a[n_got] = out_addr;
                    got_f[n_got] = out_first_in_tile;
                    got_l[n_got] = out_last_in_tile;
                    got_e[n_got] = out_last;
                end
                n_got++;
                since = 0;
            end else if (out_valid) begin
                have_prev = 1;
                pv = {out_row, out_col, out_addr, out_first_in_tile, out_last_in_tile, out_last};
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({busy, done, out_valid, out_first_in_tile, out_last_in_tile, out_last} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags got %b exp 000000",
                     {busy, done, out_valid, out_first_in_tile, out_last_in_tile, out_last});
        end
        tests++;
        if (out_row !== 8'd0 || out_col !== 8'd0 || out_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_coord got (%0d,%0d) a=%h exp (0,0) a=0", out_row, out_col, out_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset got valid=%b busy=%b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_col_first();
        start_run(1'b1, 2, 4, 1, 1, 32'h100, 32'd8);
        capture(15, 0);
        tests++;
        if (n_got != 15) begin fails++; $display("FAIL cf_count got %0d exp 15", n_got); end
        for (int i = 0; i < 15 && i < n_got; i++) begin
            tests++;
            if (int'(got_r[i]) != cf_r[i] || int'(got_c[i]) != cf_c[i] ||
                got_a[i] !== 32'h100 + 32'(cf_r[i] * 8 + cf_c[i]) ||
                got_f[i] !== cf_first[i] || got_l[i] !== cf_lastt[i] || got_e[i] !== (i == 14)) begin
                fails++;
                $display("FAIL cf_elem[%0d] got (%0d,%0d) a=%h f%b l%b e%b exp (%0d,%0d) a=%h f%b l%b e%b",
                         i, got_r[i], got_c[i], got_a[i], got_f[i], got_l[i], got_e[i],
                         cf_r[i], cf_c[i], 32'h100 + 32'(cf_r[i] * 8 + cf_c[i]),
                         cf_first[i], cf_lastt[i], (i == 14));
            end
        end
        tests++;
        if (got_a[9] !== 32'h10C || got_l[9] !== 1'b1) begin
            fails++;
            $display("FAIL cf_elem_1_4 got a=%h l%b exp a=10c l1", got_a[9], got_l[9]);
        end
        tests++;
        if (done_lat != 1 || done_cnt != 1 || valid_in_done != 0) begin
            fails++;
            $display("FAIL cf_done got lat=%0d cnt=%0d vld=%0d exp 1 1 0", done_lat, done_cnt, valid_in_done);
        end
    endtask

    task automatic test_row_first();
        start_run(1'b0, 2, 4, 1, 1, 32'h100, 32'd8);
        capture(15, 0);
        tests++;
        if (n_got != 15) begin fails++; $display("FAIL rf_count got %0d exp 15", n_got); end
        for (int i = 0; i < 15 && i < n_got; i++) begin
            tests++;
            if (int'(got_r[i]) != rf_r[i] || int'(got_c[i]) != rf_c[i] ||
                got_a[i] !== 32'h100 + 32'(rf_r[i] * 8 + rf_c[i]) ||
                got_f[i] !== rf_first[i] || got_l[i] !== rf_lastt[i] || got_e[i] !== (i == 14)) begin
                fails++;
                $display("FAIL rf_elem[%0d] got (%0d,%0d) a=%h f%b l%b e%b exp (%0d,%0d) f%b l%b e%b",
                         i, got_r[i], got_c[i], got_a[i], got_f[i], got_l[i], got_e[i],
                         rf_r[i], rf_c[i], rf_first[i], rf_lastt[i], (i == 14));
            end
        end
        tests++;
        if (done_lat != 1 || done_cnt != 1) begin
            fails++;
            $display("FAIL rf_done got lat=%0d cnt=%0d exp 1 1", done_lat, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        start_run(1'b1, 2, 4, 1, 1, 32'h100, 32'd8);
        capture(15, 30);
        tests++;
        if (n_got != 15) begin fails++; $display("FAIL bp_count got %0d exp 15", n_got); end
        for (int i = 0; i < 15 && i < n_got; i++) begin
            tests++;
            if (int'(got_r[i]) != cf_r[i] || int'(got_c[i]) != cf_c[i] ||
                got_a[i] !== 32'h100 + 32'(cf_r[i] * 8 + cf_c[i]) ||
                got_f[i] !== cf_first[i] || got_l[i] !== cf_lastt[i] || got_e[i] !== (i == 14)) begin
                fails++;
                $display("FAIL bp_elem[%0d] got (%0d,%0d) a=%h exp (%0d,%0d)",
                         i, got_r[i], got_c[i], got_a[i], cf_r[i], cf_c[i]);
            end
        end
        tests++;
        if (stall_bad != 0) begin fails++; $display("FAIL bp_stable got %0d changes exp 0", stall_bad); end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL bp_done got %0d pulses exp 1", done_cnt); end
    endtask

    task automatic test_single();
        start_run(1'b1, 0, 0, 3, 3, 32'h40, 32'd8);
        capture(1, 0);
        tests++;
        if (n_got != 1 || got_r[0] !== 8'd0 || got_c[0] !== 8'd0 || got_a[0] !== 32'h40 ||
            {got_f[0], got_l[0], got_e[0]} !== 3'b111) begin
            fails++;
            $display("FAIL single_elem got n=%0d (%0d,%0d) a=%h fle=%b exp n=1 (0,0) a=40 fle=111",
                     n_got, got_r[0], got_c[0], got_a[0], {got_f[0], got_l[0], got_e[0]});
        end
        tests++;
        if (done_lat != 1 || done_cnt != 1) begin
            fails++;
            $display("FAIL single_done got lat=%0d cnt=%0d exp 1 1", done_lat, done_cnt);
        end
    endtask

    task automatic test_clear_and_ignore_start();
        start_run(1'b1, 2, 4, 1, 1, 32'h100, 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; base_addr = 32'h900; num_col_m1 = 8'd0;
            end
            @(negedge clk);
            start = 1'b0;
        end
        tests++;
        if (out_valid !== 1'b1 || out_row !== 8'd0 || out_col !== 8'd3 || out_addr !== 32'h103) begin
            fails++;
            $display("FAIL start_ignored got v=%b (%0d,%0d) a=%h exp v=1 (0,3) a=103",
                     out_valid, out_row, out_col, out_addr);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL clear_abort got v=%b busy=%b done=%b exp 0 0 0", out_valid, busy, done);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_no_done got done=%b v=%b exp 0 0", done, out_valid);
        end
        start_run(1'b1, 2, 4, 1, 1, 32'h100, 32'd8);
        tests++;
        if (out_valid !== 1'b1 || out_row !== 8'd0 || out_col !== 8'd0 ||
            out_addr !== 32'h100 || out_first_in_tile !== 1'b1) begin
            fails++;
            $display("FAIL restart got v=%b (%0d,%0d) a=%h f=%b exp v=1 (0,0) a=100 f=1",
                     out_valid, out_row, out_col, out_addr, out_first_in_tile);
        end
        capture(15, 0);
        tests++;
        if (n_got != 15 || done_cnt != 1) begin
            fails++;
            $display("FAIL restart_complete got n=%0d done=%0d exp 15 1", n_got, done_cnt);
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] exp_a[4];
        exp_a = '{32'hFFFFFFF8, 32'hFFFFFFF9, 32'h0, 32'h1};
        start_run(1'b1, 1, 1, 1, 1, 32'hFFFFFFF8, 32'd8);
        capture(4, 0);
        tests++;
        if (n_got != 4) begin fails++; $display("FAIL wrap_count got %0d exp 4", n_got); end
        for (int i = 0; i < 4 && i < n_got; i++) begin
            tests++;
            if (got_a[i] !== exp_a[i]) begin
                fails++;
                $display("FAIL wrap_addr[%0d] got %h exp %h", i, got_a[i], exp_a[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_col_first();
        test_row_first();
        test_backpressure();
        test_single();
        test_clear_and_ignore_start();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
